alu_ctrl: RTL

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl_if.sv | 39 +++
 rtl/alu_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/alu_ctrl_if.sv
// Command, downstream-ALU and result bundle for alu_ctrl.
// The res_ovf member exists only when ALU_CTRL_OVF_EN is defined.
interface alu_ctrl_if #(parameter int WIDTH = 8);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] bus_a;
  logic [WIDTH-1:0] bus_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_out;
  logic             zero;
  logic             negative;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  logic             res_neg;
  logic [WIDTH-1:0] acc;
`ifdef ALU_CTRL_OVF_EN
  logic             res_ovf;
`endif

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, alu_out, zero, negative, res_ready,
    output cmd_ready, bus_a, bus_b, alu_sel, res_valid, res_data, res_zero, res_neg, acc
`ifdef ALU_CTRL_OVF_EN
    , res_ovf
`endif
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, alu_out, zero, negative, res_ready,
    input  cmd_ready, bus_a, bus_b, alu_sel, res_valid, res_data, res_zero, res_neg, acc
`ifdef ALU_CTRL_OVF_EN
    , res_ovf
`endif
  );
endinterface

// File: rtl/alu_ctrl.sv
// Accumulator controller sequencing an external ALU: IDLE -> EXEC -> RESP.
// Define ALU_CTRL_OVF_EN to add the signed-overflow result flag (res_ovf).
module alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  alu_ctrl_if.slave io
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_HALVE = 3'd4;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_zero_q, res_zero_d;
  logic             res_neg_q, res_neg_d;

`ifdef ALU_CTRL_OVF_EN
  logic                    res_ovf_q, res_ovf_d;
  logic                    ovf;
  logic signed [2*WIDTH-1:0] prod;

  // The ALU only returns WIDTH bits, so MUL overflow needs the full product here.
  always_comb begin
    prod = $signed({{WIDTH{acc_q[WIDTH-1]}}, acc_q}) *
           $signed({{WIDTH{data_q[WIDTH-1]}}, data_q});
    case (op_q)
      OP_ADD:  ovf = (acc_q[WIDTH-1] == data_q[WIDTH-1]) &&
                     (io.alu_out[WIDTH-1] != acc_q[WIDTH-1]);
      OP_SUB:  ovf = (acc_q[WIDTH-1] != data_q[WIDTH-1]) &&
                     (io.alu_out[WIDTH-1] != acc_q[WIDTH-1]);
      OP_MUL:  ovf = (prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod[WIDTH-1]}});
      default: ovf = 1'b0;
    endcase
  end

  assign io.res_ovf = res_ovf_q;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    acc_d      = acc_q;
    res_data_d = res_data_q;
    res_zero_d = res_zero_q;
    res_neg_d  = res_neg_q;
`ifdef ALU_CTRL_OVF_EN
    res_ovf_d  = res_ovf_q;
`endif
    io.cmd_ready = (state_q == IDLE);
    io.res_valid = (state_q == RESP);
    io.bus_a     = acc_q;
    io.bus_b     = '0;
    io.alu_sel   = OP_LOAD;

    case (state_q)
      IDLE: begin
        if (io.cmd_valid) begin
          op_d    = io.cmd_op;
          data_d  = io.cmd_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // LOAD is a pass-through of bus_a; NOPs pass acc through unchanged.
        if (op_q == OP_LOAD) begin
          io.bus_a = data_q;
        end else begin
          io.bus_b   = data_q;
          io.alu_sel = (op_q <= OP_HALVE) ? op_q : OP_LOAD;
        end
        acc_d      = io.alu_out;
        res_data_d = io.alu_out;
        res_zero_d = io.zero;
        res_neg_d  = io.negative;
`ifdef ALU_CTRL_OVF_EN
        res_ovf_d  = ovf;
`endif
        state_d    = RESP;
      end
      RESP: begin
        if (io.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      data_q     <= '0;
      acc_q      <= '0;
      res_data_q <= '0;
      res_zero_q <= 1'b0;
      res_neg_q  <= 1'b0;
`ifdef ALU_CTRL_OVF_EN
      res_ovf_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      acc_q      <= acc_d;
      res_data_q <= res_data_d;
      res_zero_q <= res_zero_d;
      res_neg_q  <= res_neg_d;
`ifdef ALU_CTRL_OVF_EN
      res_ovf_q  <= res_ovf_d;
`endif
    end
  end

  assign io.res_data = res_data_q;
  assign io.res_zero = res_zero_q;
  assign io.res_neg  = res_neg_q;
  assign io.acc      = acc_q;
endmodule
